// File: rtl/axi_log_event_arbiter.sv
// axi_log_event_arbiter
// Snoops AR/AW handshakes into one small FIFO per channel and drains them
// round-robin, one event per cycle, into the single event stream of the AXI
// BRAM logger. Events lost to a full FIFO are counted per channel.
module axi_log_event_arbiter #(
    parameter int unsigned AXI_ADDR_BITW = 32,
    parameter int unsigned AXI_ID_BITW   = 8,
    parameter int unsigned AXI_LEN_BITW  = 8,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned DROP_CNT_BITW = 16
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RI,
    input  logic                     ArValid_SI,
    input  logic                     ArReady_SI,
    input  logic [AXI_ID_BITW-1:0]   ArId_DI,
    input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
    input  logic                     AwValid_SI,
    input  logic                     AwReady_SI,
    input  logic [AXI_ID_BITW-1:0]   AwId_DI,
    input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
    input  logic                     Clear_SI,
    input  logic                     LoggerFull_SI,
    output logic                     LogValid_SO,
    output logic [AXI_ID_BITW:0]     LogId_DO,
    output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
    output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
    output logic [DROP_CNT_BITW-1:0] ArDrops_DO,
    output logic [DROP_CNT_BITW-1:0] AwDrops_DO,
    output logic                     Overflow_SO
);

    localparam int unsigned ENTRY_BITW = AXI_ID_BITW + AXI_ADDR_BITW + AXI_LEN_BITW;
    localparam int unsigned PTR_BITW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_BITW   = PTR_BITW + 1;

    // Channel index 0 = AR, 1 = AW throughout.
    logic [ENTRY_BITW-1:0]    mem [2][FIFO_DEPTH];
    logic [PTR_BITW-1:0]      wr_ptr [2];
    logic [PTR_BITW-1:0]      rd_ptr [2];
    logic [CNT_BITW-1:0]      count [2];
    logic [DROP_CNT_BITW-1:0] drop_cnt [2];
    logic [ENTRY_BITW-1:0]    entry [2];
    logic [ENTRY_BITW-1:0]    head [2];
    logic [ENTRY_BITW-1:0]    head_sel;
    logic [1:0]               evt;
    logic [1:0]               push;
    logic [1:0]               pop;
    logic [1:0]               drop;
    logic [1:0]               nonempty;
    logic                     rr_aw;

    // Capture, arbitration and drop decisions for the current cycle.
    always_comb begin
        evt      = {AwValid_SI & AwReady_SI, ArValid_SI & ArReady_SI};
        entry[0] = {ArId_DI, ArAddr_DI, ArLen_DI};
        entry[1] = {AwId_DI, AwAddr_DI, AwLen_DI};
        pop      = '0;
        push     = '0;
        drop     = '0;
        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (count[i] != '0);
            head[i]     = mem[i][rd_ptr[i]];
        end
        if (!Clear_SI && !LoggerFull_SI) begin
            if (nonempty[0] && (!nonempty[1] || !rr_aw)) begin
                pop[0] = 1'b1;
            end else if (nonempty[1]) begin
                pop[1] = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (evt[i] && !Clear_SI) begin
                if ((count[i] < CNT_BITW'(FIFO_DEPTH)) || pop[i]) begin
                    push[i] = 1'b1;
                end else begin
                    drop[i] = 1'b1;
                end
            end
        end
        head_sel = pop[1] ? head[1] : head[0];
    end

    // FIFO storage; contents need no reset since occupancy is tracked by count.
    always_ff @(posedge Clk_CI) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= entry[i];
            end
        end
    end

    // FIFO pointers, drop counters, round-robin pointer and output registers.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
                count[i]    <= '0;
                drop_cnt[i] <= '0;
            end
            rr_aw       <= 1'b0;
            Overflow_SO <= 1'b0;
            LogValid_SO <= 1'b0;
            LogId_DO    <= '0;
            LogAddr_DO  <= '0;
            LogLen_DO   <= '0;
        end else if (Clear_SI) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
                count[i]    <= '0;
                drop_cnt[i] <= '0;
            end
            rr_aw       <= 1'b0;
            Overflow_SO <= 1'b0;
            LogValid_SO <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_BITW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_BITW'(1);
                end
                count[i] <= count[i] + CNT_BITW'(push[i]) - CNT_BITW'(pop[i]);
                if (drop[i] && (drop_cnt[i] != '1)) begin
                    drop_cnt[i] <= drop_cnt[i] + DROP_CNT_BITW'(1);
                end
            end
            if (|drop) begin
                Overflow_SO <= 1'b1;
            end
            if (|pop) begin
                rr_aw       <= pop[0];
                LogValid_SO <= 1'b1;
                {LogId_DO, LogAddr_DO, LogLen_DO} <= {pop[1], head_sel};
            end else begin
                LogValid_SO <= 1'b0;
            end
        end
    end

    assign ArDrops_DO = drop_cnt[0];
    assign AwDrops_DO = drop_cnt[1];

endmodule

// File: tb/tb_axi_log_event_arbiter.sv
// tb_axi_log_event_arbiter
// Directed scenarios followed by a randomized phase; every cycle the DUT
// outputs are compared against a queue-based reference model.
module tb_axi_log_event_arbiter;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ID_W    = 8;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned DROP_W  = 4;
    localparam int          DROP_MAX = (1 << DROP_W) - 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              ar_valid, ar_ready, aw_valid, aw_ready;
    logic [ID_W-1:0]   ar_id, aw_id;
    logic [ADDR_W-1:0] ar_addr, aw_addr;
    logic [LEN_W-1:0]  ar_len, aw_len;
    logic              clear, logger_full;
    logic              log_valid;
    logic [ID_W:0]     log_id;
    logic [ADDR_W-1:0] log_addr;
    logic [LEN_W-1:0]  log_len;
    logic [DROP_W-1:0] ar_drops, aw_drops;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ev_t               ar_q[$];
    ev_t               aw_q[$];
    int                m_ar_drops = 0;
    int                m_aw_drops = 0;
    logic              m_ovf = 1'b0;
    logic              m_pref_aw = 1'b0;
    logic              e_valid = 1'b0;
    logic [ID_W:0]     e_id = '0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [LEN_W-1:0]  e_len = '0;

    logic              msbs[$];

    axi_log_event_arbiter #(
        .AXI_ADDR_BITW (ADDR_W),
        .AXI_ID_BITW   (ID_W),
        .AXI_LEN_BITW  (LEN_W),
        .FIFO_DEPTH    (DEPTH),
        .DROP_CNT_BITW (DROP_W)
    ) dut (
        .Clk_CI        (clk),
        .Rst_RI        (rst),
        .ArValid_SI    (ar_valid),
        .ArReady_SI    (ar_ready),
        .ArId_DI       (ar_id),
        .ArAddr_DI     (ar_addr),
        .ArLen_DI      (ar_len),
        .AwValid_SI    (aw_valid),
        .AwReady_SI    (aw_ready),
        .AwId_DI       (aw_id),
        .AwAddr_DI     (aw_addr),
        .AwLen_DI      (aw_len),
        .Clear_SI      (clear),
        .LoggerFull_SI (logger_full),
        .LogValid_SO   (log_valid),
        .LogId_DO      (log_id),
        .LogAddr_DO    (log_addr),
        .LogLen_DO     (log_len),
        .ArDrops_DO    (ar_drops),
        .AwDrops_DO    (aw_drops),
        .Overflow_SO   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int win;
        ev_t e;
        win = -1;
        if (rst) begin
            ar_q.delete(); aw_q.delete();
            m_ar_drops = 0; m_aw_drops = 0; m_ovf = 1'b0; m_pref_aw = 1'b0;
            e_valid = 1'b0; e_id = '0; e_addr = '0; e_len = '0;
        end else if (clear) begin
            ar_q.delete(); aw_q.delete();
            m_ar_drops = 0; m_aw_drops = 0; m_ovf = 1'b0; m_pref_aw = 1'b0;
            e_valid = 1'b0;
        end else begin
            if (!logger_full) begin
                if (ar_q.size() > 0 && aw_q.size() > 0) win = m_pref_aw ? 1 : 0;
                else if (ar_q.size() > 0) win = 0;
                else if (aw_q.size() > 0) win = 1;
            end
            if (win == 0) begin
                e = ar_q.pop_front();
                e_valid = 1'b1; e_id = {1'b0, e.id}; e_addr = e.addr; e_len = e.len;
                m_pref_aw = 1'b1;
            end else if (win == 1) begin
                e = aw_q.pop_front();
                e_valid = 1'b1; e_id = {1'b1, e.id}; e_addr = e.addr; e_len = e.len;
                m_pref_aw = 1'b0;
            end else begin
                e_valid = 1'b0;
            end
            if (ar_valid && ar_ready) begin
                if (ar_q.size() < DEPTH) ar_q.push_back('{ar_id, ar_addr, ar_len});
                else begin
                    if (m_ar_drops < DROP_MAX) m_ar_drops++;
                    m_ovf = 1'b1;
                end
            end
            if (aw_valid && aw_ready) begin
                if (aw_q.size() < DEPTH) aw_q.push_back('{aw_id, aw_addr, aw_len});
                else begin
                    if (m_aw_drops < DROP_MAX) m_aw_drops++;
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    // One clock cycle: model update, edge, then compare every output.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("log_valid", 64'(log_valid), 64'(e_valid));
        check("log_id",    64'(log_id),    64'(e_id));
        check("log_addr",  64'(log_addr),  64'(e_addr));
        check("log_len",   64'(log_len),   64'(e_len));
        check("ar_drops",  64'(ar_drops),  64'(m_ar_drops));
        check("aw_drops",  64'(aw_drops),  64'(m_aw_drops));
        check("overflow",  64'(overflow),  64'(m_ovf));
    endtask

    task automatic idle_inputs();
        ar_valid = 1'b0; ar_ready = 1'b0; aw_valid = 1'b0; aw_ready = 1'b0;
    endtask

    task automatic drive_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [LEN_W-1:0] len);
        ar_valid = 1'b1; ar_ready = 1'b1; ar_id = id; ar_addr = addr; ar_len = len;
    endtask

    task automatic drive_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [LEN_W-1:0] len);
        aw_valid = 1'b1; aw_ready = 1'b1; aw_id = id; aw_addr = addr; aw_len = len;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; logger_full = 1'b0;
        idle_inputs();
        ar_id = '0; ar_addr = '0; ar_len = '0;
        aw_id = '0; aw_addr = '0; aw_len = '0;
        tick();
        tick();
        check("reset_valid", 64'(log_valid), 64'd0);
        check("reset_id", 64'(log_id), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        tick(); tick();

        // Single AR event: strobe two cycles after capture, one cycle only
        drive_ar(8'h12, 32'h1000, 8'd3);
        tick();
        idle_inputs();
        check("t1_lat1_valid", 64'(log_valid), 64'd0);
        tick();
        check("t1_valid", 64'(log_valid), 64'd1);
        check("t1_id", 64'(log_id), 64'h012);
        check("t1_addr", 64'(log_addr), 64'h1000);
        check("t1_len", 64'(log_len), 64'd3);
        tick();
        check("t1_single", 64'(log_valid), 64'd0);
        check("t1_hold_addr", 64'(log_addr), 64'h1000);

        // Simultaneous AR and AW events for three cycles
        do_reset();
        msbs.delete();
        for (int i = 0; i < 3; i++) begin
            drive_ar(8'(8'h20 + i), 32'(32'h2000 + 16 * i), 8'(i));
            drive_aw(8'(8'h30 + i), 32'(32'h3000 + 16 * i), 8'(i + 4));
            tick();
            if (log_valid) msbs.push_back(log_id[ID_W]);
        end
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (log_valid) msbs.push_back(log_id[ID_W]);
        end
        check("t2_count", 64'(msbs.size()), 64'd6);
        for (int i = 0; i < msbs.size() && i < 6; i++)
            check("t2_tag_order", 64'(msbs[i]), 64'(i % 2));
        check("t2_ar_drops", 64'(ar_drops), 64'd0);
        check("t2_aw_drops", 64'(aw_drops), 64'd0);

        // Logger full, six AW events into a four-deep FIFO
        logger_full = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_aw(8'(8'h40 + i), 32'(32'h4000 + 4 * i), 8'(i));
            tick();
            check("t3_no_valid", 64'(log_valid), 64'd0);
        end
        idle_inputs();
        tick();
        check("t3_aw_drops", 64'(aw_drops), 64'd2);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_ar_drops", 64'(ar_drops), 64'd0);

        // Clear pulse, then release the logger: nothing comes out
        clear = 1'b1;
        drive_aw(8'h55, 32'h5555, 8'd5);
        tick();
        clear = 1'b0;
        idle_inputs();
        logger_full = 1'b0;
        check("t4_aw_drops", 64'(aw_drops), 64'd0);
        check("t4_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_no_valid", 64'(log_valid), 64'd0);
        end

        // Full AR FIFO: push and pop on the same edge is accepted
        logger_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_ar(8'(8'h60 + i), 32'(32'h6000 + 8 * i), 8'(i));
            tick();
        end
        logger_full = 1'b0;
        drive_ar(8'h64, 32'h6020, 8'd9);
        tick();
        idle_inputs();
        check("t5_ar_drops", 64'(ar_drops), 64'd0);
        check("t5_overflow", 64'(overflow), 64'd0);
        for (int i = 0; i < 6; i++) tick();
        check("t5_last_id", 64'(log_id), 64'h064);
        check("t5_last_len", 64'(log_len), 64'd9);

        // Continuous AW stream while logger is full: counter saturates
        logger_full = 1'b1;
        for (int i = 0; i < 30; i++) begin
            drive_aw(8'(i), 32'(32'h7000 + i), 8'(i));
            tick();
        end
        check("t6_saturate", 64'(aw_drops), 64'd15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_valid", 64'(log_valid), 64'd0);
        check("t6_rst_id", 64'(log_id), 64'd0);
        check("t6_rst_addr", 64'(log_addr), 64'd0);
        check("t6_rst_drops", 64'(aw_drops), 64'd0);
        check("t6_rst_overflow", 64'(overflow), 64'd0);
        idle_inputs();
        logger_full = 1'b0;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            ar_valid    = ($urandom_range(0, 99) < 60);
            ar_ready    = ($urandom_range(0, 99) < 70);
            aw_valid    = ($urandom_range(0, 99) < 60);
            aw_ready    = ($urandom_range(0, 99) < 70);
            ar_id       = 8'($urandom);
            ar_addr     = $urandom;
            ar_len      = 8'($urandom);
            aw_id       = 8'($urandom);
            aw_addr     = $urandom;
            aw_len      = 8'($urandom);
            logger_full = ($urandom_range(0, 99) < 30);
            clear       = ($urandom_range(0, 99) < 2);
            rst         = ($urandom_range(0, 199) < 1);
            tick();
        end
        rst = 1'b0; clear = 1'b0; logger_full = 1'b0;
        idle_inputs();
        for (int i = 0; i < 12; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
